cpu_icache: RTL and testbench
=============================

// Module: cpu_icache
//
// PURPOSE
// - Direct-mapped, read-only, one-word-per-line instruction cache between the fetch stage and the memory bus.
// - Hits return the instruction in the same cycle; misses issue one 32-bit bus read, fill the line, then hit.
// - No write path, no flush port. Invalidation is by reset only.
//
// PARAMETERS
// - SIZE_LOG2  default 6   log2 of the line count (64 lines, 1 word each); index = addr[SIZE_LOG2+1:2]
//
// PORTS
// - i_clock        in   1   single clock; all state updates on the rising edge
// - i_reset        in   1   synchronous, active-high reset
// - i_request      in   1   fetch wants the word at i_address; may drop or change address any cycle
// - i_address      in   32  byte address; bits [1:0] ignored (word aligned)
// - o_rdata        out  32  instruction word; valid only while o_ready=1
// - o_ready        out  1   combinational: i_request && line valid && tag match
// - o_bus_request  out  1   bus read request, registered
// - o_bus_address  out  32  word-aligned bus read address, registered, stable while o_bus_request=1
// - i_bus_rdata    in   32  bus read data, sampled when i_bus_ready=1
// - i_bus_ready    in   1   bus completion strobe for the outstanding request
//
// BEHAVIOUR
// - Address split: index = i_address[SIZE_LOG2+1:2], tag = i_address[31:SIZE_LOG2+2].
// - Storage: data[2^SIZE_LOG2] x32 and tag[2^SIZE_LOG2] with combinational (asynchronous) read; valid bits in flops.
// - Reset values: all valid bits 0, state IDLE, o_bus_request 0, o_bus_address 0. o_ready is therefore 0 in the cycle after reset.
// - Hit: o_ready=1 and o_rdata=data[index] in the same cycle, with zero latency.
//   - o_ready and o_rdata track i_address combinationally, so the next cycle's new address never sees a stale ready.
// - FSM states:
//   - IDLE: on i_request && !hit, latch the word-aligned address, set o_bus_request=1, go to MISS.
//   - MISS: hold o_bus_request and o_bus_address.
//     - On i_bus_ready: write data/tag, set valid, drop o_bus_request, go to FILLED.
//     - o_ready stays 0 during MISS, even if a line for another address hits.
//   - FILLED: one-cycle settle, then IDLE; the retried request hits in IDLE.
//   - Miss latency: request cycle + bus wait + 2 cycles to o_ready.
// - Bus protocol:
//   - o_bus_request goes high in the cycle after the miss is detected.
//   - Once high, it and o_bus_address stay constant until the i_bus_ready cycle.
//   - It is low for at least one cycle between transactions.
//   - i_bus_ready while idle is ignored.
// - i_request dropped, or i_address changed, during MISS:
//   - The bus transaction still completes and the line is filled with the latched address.
//   - No abort.
// - Conflicting address (same index, different tag): miss; the fill overwrites the line.
// - Reset mid-MISS: FSM returns to IDLE, o_bus_request=0, valids cleared, and no fill is performed.
//   - The bus is expected to be reset too.
// - Tag compare covers all upper bits. Address 0xFFFFFFFC is cacheable with no special wrap handling.
//
// STRUCTURE
// - Shared package: FSM state encoding (IDLE/MISS/FILLED) and the SIZE_LOG2 default.
// - Single module. The data+tag array may be a sub-module cpu_icache_mem:
//   - 1 synchronous write port, 1 asynchronous read port.
//
// TESTING
// - Cold miss:
//   - reset, then i_request=1 with addr 0x00000000 -> o_bus_request=1, o_bus_address=0x0.
//   - i_bus_ready with 0x00000013 three cycles later -> o_ready=1, o_rdata=0x00000013, two cycles after the ready strobe.
// - Hit: re-request 0x00000000 -> o_ready=1, o_rdata=0x13 in the same cycle, o_bus_request stays 0.
// - Sequential stream:
//   - fill 0x0, 0x4, 0x8 with distinct data.
//   - request each back-to-back, changing address every cycle -> ready every cycle with the matching data.
// - Conflict:
//   - fill 0x000 (data A), then request 0x100 (same index, SIZE_LOG2=6) -> miss; bus fills data B.
//   - request 0x000 again -> miss again.
// - Abandoned miss:
//   - drop i_request during MISS, then assert i_bus_ready with 0xDEADBEEF.
//   - later request of the same address -> immediate hit returning 0xDEADBEEF.
// - Reset mid-miss: assert i_reset during MISS -> o_bus_request=0 next cycle; the prior hit address now misses.

Source files
------------

// File: rtl/cpu_icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
package cpu_icache_pkg;

  localparam int SIZE_LOG2_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MISS   = 2'd1,
    ST_FILLED = 2'd2
  } state_e;

endpackage

// File: rtl/cpu_icache_mem.sv
// Data + tag line storage: one synchronous write port, one asynchronous read port.
module cpu_icache_mem
  import cpu_icache_pkg::*;
#(
  parameter int SIZE_LOG2 = SIZE_LOG2_DEF,
  parameter int TAG_W     = 30 - SIZE_LOG2_DEF
) (
  input  logic                 i_clock,
  input  logic                 i_we,
  input  logic [SIZE_LOG2-1:0] i_waddr,
  input  logic [31:0]          i_wdata,
  input  logic [TAG_W-1:0]     i_wtag,
  input  logic [SIZE_LOG2-1:0] i_raddr,
  output logic [31:0]          o_rdata,
  output logic [TAG_W-1:0]     o_rtag
);

  localparam int LINES = 1 << SIZE_LOG2;

  logic [31:0]      data_q [LINES];
  logic [TAG_W-1:0] tag_q  [LINES];

  // Line fill: data and tag are written together; validity is tracked outside.
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      data_q[i_waddr] <= i_wdata;
      tag_q[i_waddr]  <= i_wtag;
    end
  end

  assign o_rdata = data_q[i_raddr];
  assign o_rtag  = tag_q[i_raddr];

endmodule

// File: rtl/cpu_icache.sv
// Direct-mapped, read-only, one-word-per-line instruction cache.
// Hits answer combinationally; a miss issues a single bus read, fills the
// line, settles one cycle and then the retried request hits.
module cpu_icache
  import cpu_icache_pkg::*;
#(
  parameter int SIZE_LOG2 = SIZE_LOG2_DEF
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic [31:0] i_address,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_bus_request,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ready
);

  localparam int LINES = 1 << SIZE_LOG2;
  localparam int TAG_W = 30 - SIZE_LOG2;

  state_e             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic               bus_req_q, bus_req_d;
  logic [31:0]        bus_addr_q, bus_addr_d;

  logic [SIZE_LOG2-1:0] rd_idx, fill_idx;
  logic [TAG_W-1:0]     rd_tag, fill_tag, line_tag;
  logic [31:0]          line_data;
  logic                 hit_raw, fill_we;
  logic                 unused_addr_lsb;

  assign rd_idx   = i_address[SIZE_LOG2+1:2];
  assign rd_tag   = i_address[31:SIZE_LOG2+2];
  assign fill_idx = bus_addr_q[SIZE_LOG2+1:2];
  assign fill_tag = bus_addr_q[31:SIZE_LOG2+2];
  // Byte offset within the word is irrelevant to a word-wide fetch.
  assign unused_addr_lsb = ^i_address[1:0];

  // Fill uses the latched miss address, so the fetch side may wander off mid-miss.
  // Reset suppresses a fill that would otherwise land in the reset cycle.
  assign fill_we = (state_q == ST_MISS) && i_bus_ready && !i_reset;

  cpu_icache_mem #(
    .SIZE_LOG2 (SIZE_LOG2),
    .TAG_W     (TAG_W)
  ) u_mem (
    .i_clock (i_clock),
    .i_we    (fill_we),
    .i_waddr (fill_idx),
    .i_wdata (i_bus_rdata),
    .i_wtag  (fill_tag),
    .i_raddr (rd_idx),
    .o_rdata (line_data),
    .o_rtag  (line_tag)
  );

  assign hit_raw       = i_request && valid_q[rd_idx] && (line_tag == rd_tag);
  // Ready only from IDLE: an unrelated hit during MISS/FILLED is held off.
  assign o_ready       = hit_raw && (state_q == ST_IDLE);
  assign o_rdata       = line_data;
  assign o_bus_request = bus_req_q;
  assign o_bus_address = bus_addr_q;

  // Miss FSM next-state, bus request/address and valid-bit updates.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    bus_req_d  = bus_req_q;
    bus_addr_d = bus_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (i_request && !hit_raw) begin
          bus_req_d  = 1'b1;
          bus_addr_d = {i_address[31:2], 2'b00};
          state_d    = ST_MISS;
        end
      end
      ST_MISS: begin
        if (i_bus_ready) begin
          valid_d[fill_idx] = 1'b1;
          bus_req_d         = 1'b0;
          state_d           = ST_FILLED;
        end
      end
      ST_FILLED: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State registers; reset invalidates every line and abandons any miss.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      valid_q    <= '0;
      bus_req_q  <= 1'b0;
      bus_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      bus_req_q  <= bus_req_d;
      bus_addr_q <= bus_addr_d;
    end
  end

endmodule

// File: tb/tb_cpu_icache.sv
// Directed vector table plus randomized traffic checked against a line-map model.
module tb_cpu_icache;

  logic        clk = 1'b0;
  logic        rst, req, brdy;
  logic [31:0] addr, bdata;
  logic [31:0] o_rdata, o_bus_address;
  logic        o_ready, o_bus_request;

  int compared   = 0;
  int mismatched = 0;

  cpu_icache dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_request     (req),
    .i_address     (addr),
    .o_rdata       (o_rdata),
    .o_ready       (o_ready),
    .o_bus_request (o_bus_request),
    .o_bus_address (o_bus_address),
    .i_bus_rdata   (bdata),
    .i_bus_ready   (brdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, req;
    logic [31:0] addr;
    logic        brdy;
    logic [31:0] bdata;
    logic        e_rdy;
    logic [31:0] e_data;
    logic        e_breq;
    logic [31:0] e_baddr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic q, input logic [31:0] a,
                     input logic b, input logic [31:0] d,
                     input logic er, input logic [31:0] ed,
                     input logic eb, input logic [31:0] ea);
    vec_t v;
    v.rst = r; v.req = q; v.addr = a; v.brdy = b; v.bdata = d;
    v.e_rdy = er; v.e_data = ed; v.e_breq = eb; v.e_baddr = ea;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic drive(input logic r, input logic q, input logic [31:0] a,
                       input logic b, input logic [31:0] d);
    @(posedge clk);
    #1;
    rst = r; req = q; addr = a; brdy = b; bdata = d;
  endtask

  // Reference model: which word address each line holds, plus outstanding-miss bookkeeping.
  logic [31:0] m_addr [64];
  logic [31:0] m_data [64];
  bit          m_v    [64];
  bit          pend;
  logic [31:0] pend_addr;
  int          settle;

  function automatic logic [31:0] rand_addr();
    logic [23:0] tg;
    logic [5:0]  ix;
    case ($urandom % 3)
      0: tg = 24'h0;
      1: tg = 24'h1;
      default: tg = 24'hFFFFFF;
    endcase
    case ($urandom % 5)
      0: ix = 6'd0;
      1: ix = 6'd1;
      2: ix = 6'd2;
      3: ix = 6'd63;
      default: ix = 6'($urandom % 64);
    endcase
    return {tg, ix, 2'($urandom % 4)};
  endfunction

  initial begin
    localparam logic [31:0] DA = 32'hAAAA_0000;
    localparam logic [31:0] DB = 32'hBBBB_0001;
    rst = 1'b1; req = 1'b0; addr = '0; brdy = 1'b0; bdata = '0;
    repeat (2) @(posedge clk);

    // Cold state right after reset: a request to 0 misses.
    drive(0, 1, 32'h0, 0, 0);
    @(negedge clk);
    chk("reset_ready", o_ready, 0);
    chk("reset_bus_req", o_bus_request, 0);
    chk("reset_bus_addr", o_bus_address, 0);

    //  rst req addr          brdy bdata          e_rdy e_data        e_breq e_baddr
    // cold miss, strobe three cycles after the request, ready two cycles later
    add(0, 1, 32'h0,        0, 0,              0, 0,             1, 32'h0);
    add(0, 1, 32'h0,        0, 0,              0, 0,             1, 32'h0);
    add(0, 1, 32'h0,        1, 32'h13,         0, 0,             1, 32'h0);
    add(0, 1, 32'h0,        0, 0,              0, 0,             0, 0);
    add(0, 1, 32'h0,        0, 0,              1, 32'h13,        0, 0);
    add(0, 1, 32'h0,        0, 0,              1, 32'h13,        0, 0);
    // conflict: 0x100 shares index 0
    add(0, 1, 32'h100,      0, 0,              0, 0,             0, 0);
    add(0, 1, 32'h100,      1, DB,             0, 0,             1, 32'h100);
    add(0, 1, 32'h100,      0, 0,              0, 0,             0, 0);
    add(0, 1, 32'h100,      0, 0,              1, DB,            0, 0);
    add(0, 1, 32'h0,        0, 0,              0, 0,             0, 0);
    add(0, 1, 32'h0,        1, DA,             0, 0,             1, 32'h0);
    add(0, 1, 32'h0,        0, 0,              0, 0,             0, 0);
    add(0, 1, 32'h0,        0, 0,              1, DA,            0, 0);
    // fill 0x4 and 0x8, then stream
    add(0, 1, 32'h4,        0, 0,              0, 0,             0, 0);
    add(0, 1, 32'h4,        1, 32'h44,         0, 0,             1, 32'h4);
    add(0, 1, 32'h4,        0, 0,              0, 0,             0, 0);
    add(0, 1, 32'h4,        0, 0,              1, 32'h44,        0, 0);
    add(0, 1, 32'h8,        0, 0,              0, 0,             0, 0);
    add(0, 1, 32'h8,        1, 32'h88,         0, 0,             1, 32'h8);
    add(0, 1, 32'h8,        0, 0,              0, 0,             0, 0);
    add(0, 1, 32'h0,        0, 0,              1, DA,            0, 0);
    add(0, 1, 32'h4,        0, 0,              1, 32'h44,        0, 0);
    add(0, 1, 32'h8,        0, 0,              1, 32'h88,        0, 0);
    add(0, 1, 32'hA,        0, 0,              1, 32'h88,        0, 0);
    // abandoned miss; an unrelated hitting address is held off during MISS
    add(0, 1, 32'h20,       0, 0,              0, 0,             0, 0);
    add(0, 0, 32'h20,       0, 0,              0, 0,             1, 32'h20);
    add(0, 1, 32'h4,        0, 0,              0, 0,             1, 32'h20);
    add(0, 0, 32'h0,        1, 32'hDEADBEEF,   0, 0,             1, 32'h20);
    add(0, 0, 32'h0,        0, 0,              0, 0,             0, 0);
    add(0, 1, 32'h20,       0, 0,              1, 32'hDEADBEEF,  0, 0);
    // bus strobe while idle is ignored; no ready without a request
    add(0, 1, 32'h20,       1, 32'h0,          1, 32'hDEADBEEF,  0, 0);
    add(0, 1, 32'h20,       0, 0,              1, 32'hDEADBEEF,  0, 0);
    add(0, 0, 32'h20,       0, 0,              0, 0,             0, 0);
    // reset mid-miss
    add(0, 1, 32'h40,       0, 0,              0, 0,             0, 0);
    add(1, 0, 32'h40,       1, 32'h4040,       0, 0,             1, 32'h40);
    add(0, 1, 32'h0,        0, 0,              0, 0,             0, 0);
    add(0, 1, 32'h0,        0, 0,              0, 0,             1, 32'h0);
    add(0, 1, 32'h0,        1, 32'h77,         0, 0,             1, 32'h0);
    add(0, 1, 32'h0,        0, 0,              0, 0,             0, 0);
    add(0, 1, 32'h0,        0, 0,              1, 32'h77,        0, 0);
    add(0, 1, 32'h40,       0, 0,              0, 0,             0, 0);
    add(0, 1, 32'h40,       1, 32'h40,         0, 0,             1, 32'h40);
    add(0, 1, 32'h40,       0, 0,              0, 0,             0, 0);
    add(0, 1, 32'h40,       0, 0,              1, 32'h40,        0, 0);

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].req, tbl[k].addr, tbl[k].brdy, tbl[k].bdata);
      @(negedge clk);
      chk($sformatf("row%0d_ready", k), o_ready, tbl[k].e_rdy);
      chk($sformatf("row%0d_bus_req", k), o_bus_request, tbl[k].e_breq);
      if (tbl[k].e_rdy)  chk($sformatf("row%0d_rdata", k), o_rdata, tbl[k].e_data);
      if (tbl[k].e_breq) chk($sformatf("row%0d_bus_addr", k), o_bus_address, tbl[k].e_baddr);
    end

    // Randomized phase from a fresh reset.
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    foreach (m_v[i]) m_v[i] = 0;
    pend = 0; pend_addr = '0; settle = 0;

    for (int c = 0; c < 3000; c++) begin
      logic        r, q, b, busy, hit;
      logic [31:0] a, d, aw;
      int          ix, pix;
      r = ($urandom % 250) == 0;
      q = ($urandom % 4) != 0;
      a = rand_addr();
      b = ($urandom % 3) == 0;
      d = $urandom;
      drive(r, q, a, b, d);
      @(negedge clk);
      aw   = {a[31:2], 2'b00};
      ix   = int'(a[7:2]);
      busy = pend || (settle != 0);
      hit  = q && m_v[ix] && (m_addr[ix] == aw);
      chk("rnd_ready", o_ready, !busy && hit);
      if (!busy && hit) chk("rnd_rdata", o_rdata, m_data[ix]);
      chk("rnd_bus_req", o_bus_request, pend);
      if (pend) chk("rnd_bus_addr", o_bus_address, pend_addr);
      // advance the model across the coming rising edge
      if (r) begin
        foreach (m_v[i]) m_v[i] = 0;
        pend = 0; settle = 0;
      end else if (pend) begin
        if (b) begin
          pix = int'(pend_addr[7:2]);
          m_v[pix] = 1; m_addr[pix] = pend_addr; m_data[pix] = d;
          pend = 0; settle = 1;
        end
      end else if (settle != 0) begin
        settle = 0;
      end else if (q && !hit) begin
        pend = 1; pend_addr = aw;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
